colour_input_arbiter: RTL and testbench

COLOUR_INPUT_ARBITER -- requirements
Module: colour_input_arbiter

---
 rtl/colour_input_arbiter.sv | 143 ++++++++++++++
 tb/tb_colour_input_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/colour_input_arbiter.sv
// colour_input_arbiter
// Accepts one colour-button press at a time for the game FSM. A round-robin
// pointer picks among simultaneously pressed buttons, the chosen colour is
// held on a valid/ready output until consumed, and a new press is only
// accepted after all buttons have been released for HOLD_OFF cycles.
//
// Output handshake: press_valid is raised in GRANT and held, with
// press_onehot/press_index stable, until an edge samples press_valid=1 and
// press_ready=1; that edge completes the transfer and drops press_valid.
module colour_input_arbiter #(
    parameter int unsigned HOLD_OFF = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] buttons,
    input  logic       enable,
    input  logic       press_ready,
    output logic       press_valid,
    output logic [3:0] press_onehot,
    output logic [1:0] press_index,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        GRANT        = 2'd1,
        WAIT_RELEASE = 2'd2,
        HOLDOFF      = 2'd3
    } state_t;

    // Last counter value of the hold-off window (HOLD_OFF cycles: 0..HOLD_OFF-1).
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_OFF - 1);

    state_t     state_q, state_d;
    logic       valid_q, valid_d;
    logic [3:0] onehot_q, onehot_d;
    logic [1:0] index_q, index_d;
    logic       busy_q, busy_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;

    logic       sel_found;
    logic [1:0] sel_idx;
    logic [1:0] cand;
    logic       any_pressed;

    assign any_pressed = |buttons;

    // Round-robin search starting at ptr: first asserted bit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!sel_found && buttons[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state and next-output computation for the acceptance FSM.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        onehot_d = onehot_q;
        index_d  = index_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (enable && any_pressed && sel_found) begin
                    onehot_d = 4'b0001 << sel_idx;
                    index_d  = sel_idx;
                    valid_d  = 1'b1;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                // Buttons and enable are ignored here; only the consumer moves us on.
                valid_d = 1'b1;
                if (press_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = index_q + 2'd1;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                valid_d = 1'b0;
                if (!any_pressed) begin
                    cnt_d   = 8'd0;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                valid_d = 1'b0;
                if (any_pressed) begin
                    state_d = WAIT_RELEASE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset discards any pending press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            onehot_q <= 4'b0000;
            index_q  <= 2'd0;
            busy_q   <= 1'b0;
            ptr_q    <= 2'd0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            index_q  <= index_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_valid  = valid_q;
    assign press_onehot = onehot_q;
    assign press_index  = index_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_colour_input_arbiter.sv
// Directed bench for colour_input_arbiter (HOLD_OFF=8 main instance,
// HOLD_OFF=1 second instance for the minimum hold-off window).
module tb_colour_input_arbiter;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_HOLDOFF = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buttons;
    logic       enable;
    logic       press_ready;
    logic       press_valid;
    logic [3:0] press_onehot;
    logic [1:0] press_index;
    logic       busy;
    logic [1:0] state_dbg;

    logic [3:0] buttons1;
    logic       enable1;
    logic       press_ready1;
    logic       press_valid1;
    logic [3:0] press_onehot1;
    logic [1:0] press_index1;
    logic       busy1;
    logic [1:0] state_dbg1;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    colour_input_arbiter #(.HOLD_OFF(8)) u_dut (
        .clk(clk), .reset(reset), .buttons(buttons), .enable(enable),
        .press_ready(press_ready), .press_valid(press_valid),
        .press_onehot(press_onehot), .press_index(press_index),
        .busy(busy), .state_dbg(state_dbg)
    );

    colour_input_arbiter #(.HOLD_OFF(1)) u_dut1 (
        .clk(clk), .reset(reset), .buttons(buttons1), .enable(enable1),
        .press_ready(press_ready1), .press_valid(press_valid1),
        .press_onehot(press_onehot1), .press_index(press_index1),
        .busy(busy1), .state_dbg(state_dbg1)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven afterwards are sampled at the next edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] oh, input logic [1:0] idx);
        check_eq({tag, "_valid"}, 8'(press_valid), 8'd1);
        check_eq({tag, "_onehot"}, 8'(press_onehot), 8'(oh));
        check_eq({tag, "_index"}, 8'(press_index), 8'(idx));
        check_eq({tag, "_busy"}, 8'(busy), 8'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_valid"}, 8'(press_valid), 8'd0);
        check_eq({tag, "_onehot"}, 8'(press_onehot), 8'd0);
        check_eq({tag, "_index"}, 8'(press_index), 8'd0);
        check_eq({tag, "_busy"}, 8'(busy), 8'd0);
        check_eq({tag, "_state"}, 8'(state_dbg), 8'(S_IDLE));
    endtask

    task automatic handshake(input string tag);
        press_ready = 1'b1;
        step();
        press_ready = 1'b0;
        check_eq({tag, "_hs_valid"}, 8'(press_valid), 8'd0);
        check_eq({tag, "_hs_state"}, 8'(state_dbg), 8'(S_WAIT));
    endtask

    // Full release then exactly HOLD_OFF (8) quiet cycles in HOLDOFF.
    task automatic release_to_idle(input string tag);
        buttons = 4'b0000;
        step();
        check_eq({tag, "_rel_state"}, 8'(state_dbg), 8'(S_HOLDOFF));
        step(7);
        check_eq({tag, "_hold7_state"}, 8'(state_dbg), 8'(S_HOLDOFF));
        step();
        check_eq({tag, "_idle_state"}, 8'(state_dbg), 8'(S_IDLE));
        check_eq({tag, "_idle_busy"}, 8'(busy), 8'd0);
    endtask

    initial begin
        reset = 1'b1; buttons = 4'b0000; enable = 1'b0; press_ready = 1'b0;
        buttons1 = 4'b0000; enable1 = 1'b0; press_ready1 = 1'b0;
        step(2);
        check_reset_vals("rst");
        reset = 1'b0;

        // single press
        enable = 1'b1; buttons = 4'b0100;
        step();
        check_grant("single", 4'b0100, 2'd2);

        // back-pressure with changing buttons
        buttons = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            step();
            check_grant("bp", 4'b0100, 2'd2);
        end
        handshake("bp");
        check_eq("bp_retain_onehot", 8'(press_onehot), 8'h04);
        step();
        check_eq("bp_held_state", 8'(state_dbg), 8'(S_WAIT));

        // hold-off interrupted after 5 released cycles (ptr now 3)
        buttons = 4'b0000;
        step();
        check_eq("ho_enter", 8'(state_dbg), 8'(S_HOLDOFF));
        step(4);
        buttons = 4'b0001;
        step();
        check_eq("ho_abort_state", 8'(state_dbg), 8'(S_WAIT));
        check_eq("ho_abort_valid", 8'(press_valid), 8'd0);
        release_to_idle("ho");
        buttons = 4'b0001;
        step();
        check_grant("ho_grant", 4'b0001, 2'd0);
        handshake("ho");

        // round-robin from ptr=0
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("rr_rst");
        buttons = 4'b1111;
        step();
        check_grant("rr0", 4'b0001, 2'd0);
        handshake("rr0");
        release_to_idle("rr0");
        buttons = 4'b1111;
        step();
        check_grant("rr1", 4'b0010, 2'd1);
        handshake("rr1");
        release_to_idle("rr1");
        buttons = 4'b1111;
        step();
        check_grant("rr2", 4'b0100, 2'd2);
        handshake("rr2");
        release_to_idle("rr2");
        buttons = 4'b1111;
        step();
        check_grant("rr3", 4'b1000, 2'd3);
        handshake("rr3");
        release_to_idle("rr3");
        buttons = 4'b1111;
        step();
        check_grant("rr4", 4'b0001, 2'd0);
        handshake("rr4");
        release_to_idle("rr4");

        // enable gating (ptr=1)
        enable = 1'b0; buttons = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("en_gate_valid", 8'(press_valid), 8'd0);
            check_eq("en_gate_busy", 8'(busy), 8'd0);
        end
        enable = 1'b1;
        step();
        check_grant("en_grant", 4'b0010, 2'd1);
        // dropping enable mid-transaction must not abort it
        enable = 1'b0;
        step(2);
        check_grant("en_drop", 4'b0010, 2'd1);
        handshake("en_drop");
        enable = 1'b1;
        release_to_idle("en");

        // reset mid-GRANT (ptr=2)
        buttons = 4'b0100;
        step();
        check_grant("mid", 4'b0100, 2'd2);
        reset = 1'b1;
        step();
        check_reset_vals("mid_rst1");
        step();
        check_reset_vals("mid_rst2");
        reset = 1'b0; buttons = 4'b1111;
        step();
        check_grant("mid_ptr0", 4'b0001, 2'd0);

        // HOLD_OFF=1: exactly one quiet HOLDOFF cycle
        enable1 = 1'b1; buttons1 = 4'b1000;
        step();
        check_eq("h1_valid", 8'(press_valid1), 8'd1);
        check_eq("h1_index", 8'(press_index1), 8'd3);
        press_ready1 = 1'b1;
        step();
        press_ready1 = 1'b0;
        check_eq("h1_wait", 8'(state_dbg1), 8'(S_WAIT));
        buttons1 = 4'b0000;
        step();
        check_eq("h1_holdoff", 8'(state_dbg1), 8'(S_HOLDOFF));
        step();
        check_eq("h1_idle", 8'(state_dbg1), 8'(S_IDLE));
        buttons1 = 4'b1001;
        step();
        check_eq("h1_regrant_index", 8'(press_index1), 8'd0);
        check_eq("h1_regrant_onehot", 8'(press_onehot1), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
